motion_controller: RTL and testbench

MOTION_CONTROLLER -- requirements
Module: motion_controller

---
 rtl/motion_controller.sv | 176 +++++++++++++++++
 tb/tb_motion_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_controller.sv
// Line-following motion controller: debounced track decoding, obstacle
// blocking, turn watchdog and a two-channel frame-synchronous PWM.
module motion_controller #(
  parameter int unsigned PWM_PERIOD   = 256,
  parameter int unsigned SPEED_FAST   = 192,
  parameter int unsigned SPEED_SLOW   = 64,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned CLEAR_CYCLES = 8,
  parameter int unsigned TURN_MAX     = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] track_state,
  input  logic       obstacle,
  input  logic       start,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic [2:0] mode
);

  localparam int unsigned CW = $clog2(PWM_PERIOD + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam int unsigned KW = $clog2(CLEAR_CYCLES + 1);
  localparam int unsigned TW = $clog2(TURN_MAX + 1);

  localparam logic [2:0] MODE_IDLE    = 3'd0;
  localparam logic [2:0] MODE_FWD     = 3'd1;
  localparam logic [2:0] MODE_TURN_L  = 3'd2;
  localparam logic [2:0] MODE_TURN_R  = 3'd3;
  localparam logic [2:0] MODE_BLOCKED = 3'd4;
  localparam logic [2:0] MODE_HALT    = 3'd5;

  localparam logic [1:0] TRK_STOP = 2'd0;
  localparam logic [1:0] TRK_STRI = 2'd1;
  localparam logic [1:0] TRK_RT   = 2'd2;
  localparam logic [1:0] TRK_LT   = 2'd3;

  logic [1:0]    filt_state;
  logic [1:0]    cand_state;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] run_len;
  logic          obs_q;
  logic [2:0]    mode_nxt;
  logic [TW-1:0] turn_cnt;
  logic [KW-1:0] clr_cnt;
  logic          in_turn;
  logic          turn_timeout;
  logic          moving;
  logic [CW-1:0] pwm_cnt;
  logic [CW-1:0] duty_l;
  logic [CW-1:0] duty_r;
  logic [CW-1:0] tgt_l;
  logic [CW-1:0] tgt_r;

  // Length of the current run of identical samples that differ from filt_state
  always_comb begin
    run_len = DW'(1);
    if (deb_cnt != '0 && track_state == cand_state)
      run_len = deb_cnt + DW'(1);
  end

  // Track-code debounce filter
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_state <= TRK_STRI;
      cand_state <= TRK_STRI;
      deb_cnt    <= '0;
    end else if (track_state == filt_state) begin
      deb_cnt <= '0;
    end else begin
      cand_state <= track_state;
      if (run_len == DW'(DEBOUNCE)) begin
        filt_state <= track_state;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= run_len;
      end
    end
  end

  // Obstacle synchroniser stage
  always_ff @(posedge clk) begin
    if (reset) obs_q <= 1'b0;
    else       obs_q <= obstacle;
  end

  assign in_turn      = (mode == MODE_TURN_L) || (mode == MODE_TURN_R);
  assign turn_timeout = in_turn && (turn_cnt == TW'(TURN_MAX - 1));
  assign moving       = (mode == MODE_FWD) || in_turn;

  // Mode next-state decode
  always_comb begin
    mode_nxt = mode;
    case (mode)
      MODE_IDLE, MODE_HALT: begin
        if (start) mode_nxt = MODE_FWD;
      end
      MODE_FWD, MODE_TURN_L, MODE_TURN_R: begin
        if (obs_q)             mode_nxt = MODE_BLOCKED;
        else if (turn_timeout) mode_nxt = MODE_HALT;
        else begin
          case (filt_state)
            TRK_STOP: mode_nxt = MODE_HALT;
            TRK_STRI: mode_nxt = MODE_FWD;
            TRK_LT:   mode_nxt = MODE_TURN_L;
            default:  mode_nxt = MODE_TURN_R;
          endcase
        end
      end
      MODE_BLOCKED: begin
        if (!obs_q && clr_cnt == KW'(CLEAR_CYCLES - 1)) mode_nxt = MODE_FWD;
      end
      default: mode_nxt = MODE_IDLE;
    endcase
  end

  // Mode register
  always_ff @(posedge clk) begin
    if (reset) mode <= MODE_IDLE;
    else       mode <= mode_nxt;
  end

  // Turn watchdog: restarts whenever a (different) turn mode is entered
  always_ff @(posedge clk) begin
    if (reset)
      turn_cnt <= '0;
    else if ((mode_nxt == MODE_TURN_L || mode_nxt == MODE_TURN_R) && mode_nxt != mode)
      turn_cnt <= '0;
    else if (in_turn && mode_nxt == mode)
      turn_cnt <= turn_cnt + TW'(1);
  end

  // Obstacle-free run counter used to leave BLOCKED
  always_ff @(posedge clk) begin
    if (reset || mode != MODE_BLOCKED || obs_q)
      clr_cnt <= '0;
    else if (clr_cnt == KW'(CLEAR_CYCLES - 1))
      clr_cnt <= '0;
    else
      clr_cnt <= clr_cnt + KW'(1);
  end

  // Per-mode target duty
  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    case (mode)
      MODE_FWD:    begin tgt_l = CW'(SPEED_FAST); tgt_r = CW'(SPEED_FAST); end
      MODE_TURN_L: begin tgt_l = CW'(SPEED_SLOW); tgt_r = CW'(SPEED_FAST); end
      MODE_TURN_R: begin tgt_l = CW'(SPEED_FAST); tgt_r = CW'(SPEED_SLOW); end
      default:     begin tgt_l = '0;              tgt_r = '0;              end
    endcase
  end

  // Free-running frame counter; duties latch only at the frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty_l  <= '0;
      duty_r  <= '0;
    end else if (pwm_cnt == CW'(PWM_PERIOD - 1)) begin
      pwm_cnt <= '0;
      duty_l  <= tgt_l;
      duty_r  <= tgt_r;
    end else begin
      pwm_cnt <= pwm_cnt + CW'(1);
    end
  end

  // Outputs gated by mode so a stop takes effect mid-frame
  always_comb begin
    left_pwm  = moving && (pwm_cnt < duty_l);
    right_pwm = moving && (pwm_cnt < duty_r);
  end

endmodule

// File: tb/tb_motion_controller.sv
// Directed bench for motion_controller with small PWM/turn parameters.
module tb_motion_controller;

  logic       clk;
  logic       reset;
  logic [1:0] track_state;
  logic       obstacle;
  logic       start;
  logic       left_pwm;
  logic       right_pwm;
  logic [2:0] mode;

  int n_cmp = 0;
  int n_err = 0;
  int frame_pos = 0;

  motion_controller #(
    .PWM_PERIOD  (16),
    .SPEED_FAST  (12),
    .SPEED_SLOW  (4),
    .DEBOUNCE    (4),
    .CLEAR_CYCLES(8),
    .TURN_MAX    (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .track_state(track_state),
    .obstacle   (obstacle),
    .start      (start),
    .left_pwm   (left_pwm),
    .right_pwm  (right_pwm),
    .mode       (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame position: counts edges since the last reset edge, mod 16
  always @(posedge clk) begin
    if (reset) frame_pos <= 0;
    else       frame_pos <= (frame_pos == 15) ? 0 : frame_pos + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count high cycles of each output over one whole frame starting at position 0
  task automatic measure_frame(output int lh, output int rh);
    int guard;
    lh = 0;
    rh = 0;
    guard = 0;
    step(1);
    while (frame_pos != 0 && guard < 20) begin
      step(1);
      guard++;
    end
    n_cmp++;
    if (frame_pos != 0) begin
      n_err++;
      $display("FAIL frame_align: pos %0d want 0", frame_pos);
    end
    for (int i = 0; i < 16; i++) begin
      if (left_pwm)  lh++;
      if (right_pwm) rh++;
      step(1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; track_state = 2'd1; obstacle = 1'b0;
    step(2);
    n_cmp++; if (mode !== 3'd0) begin n_err++; $display("FAIL reset_mode: got %0d want 0", mode); end
    n_cmp++; if (left_pwm !== 1'b0 || right_pwm !== 1'b0) begin n_err++;
      $display("FAIL reset_pwm: got %b%b want 00", left_pwm, right_pwm); end
    reset = 1'b0;
    obstacle = 1'b1;
    step(4);
    n_cmp++; if (mode !== 3'd0) begin n_err++; $display("FAIL idle_ignores: got %0d want 0", mode); end
    obstacle = 1'b0;
    step(2);
  endtask

  task automatic test_fwd;
    int lh, rh;
    track_state = 2'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL start_fwd: got %0d want 1", mode); end
    measure_frame(lh, rh);
    n_cmp++; if (lh !== 12 || rh !== 12) begin n_err++;
      $display("FAIL fwd_duty: got %0d/%0d want 12/12", lh, rh); end
  endtask

  task automatic test_debounce;
    int lh, rh;
    track_state = 2'd3;
    step(3);
    track_state = 2'd1;
    step(5);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL short_glitch: got %0d want 1", mode); end
    track_state = 2'd3;
    step(4);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL lt_filt_edge: got %0d want 1", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd2) begin n_err++; $display("FAIL lt_mode: got %0d want 2", mode); end
    measure_frame(lh, rh);
    n_cmp++; if (lh !== 4 || rh !== 12) begin n_err++;
      $display("FAIL turn_l_duty: got %0d/%0d want 4/12", lh, rh); end
  endtask

  task automatic test_blocked;
    int lh, rh;
    track_state = 2'd1;
    step(4);
    n_cmp++; if (mode !== 3'd2) begin n_err++; $display("FAIL stri_filt_edge: got %0d want 2", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL back_fwd: got %0d want 1", mode); end
    measure_frame(lh, rh);
    n_cmp++; if (lh !== 12 || rh !== 12) begin n_err++;
      $display("FAIL fwd_duty2: got %0d/%0d want 12/12", lh, rh); end
    step(5);
    obstacle = 1'b1;
    step(1);
    n_cmp++; if (mode !== 3'd1 || left_pwm !== 1'b1) begin n_err++;
      $display("FAIL obs_lag: got mode %0d pwm %b want 1/1", mode, left_pwm); end
    step(1);
    n_cmp++; if (mode !== 3'd4) begin n_err++; $display("FAIL blocked: got %0d want 4", mode); end
    n_cmp++; if (left_pwm !== 1'b0 || right_pwm !== 1'b0) begin n_err++;
      $display("FAIL blocked_pwm: got %b%b want 00", left_pwm, right_pwm); end
    obstacle = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    n_cmp++; if (mode !== 3'd4) begin n_err++; $display("FAIL clear7: got %0d want 4", mode); end
    obstacle = 1'b1;
    step(1);
    obstacle = 1'b0;
    step(1);
    n_cmp++; if (mode !== 3'd4) begin n_err++; $display("FAIL glitch_hold: got %0d want 4", mode); end
    step(7);
    n_cmp++; if (mode !== 3'd4) begin n_err++; $display("FAIL clear_pre: got %0d want 4", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL clear_exit: got %0d want 1", mode); end
  endtask

  task automatic test_turn_timeout;
    track_state = 2'd2;
    step(4);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL rt_filt_edge: got %0d want 1", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd3) begin n_err++; $display("FAIL rt_mode: got %0d want 3", mode); end
    step(63);
    n_cmp++; if (mode !== 3'd3) begin n_err++; $display("FAIL turn_last: got %0d want 3", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd5) begin n_err++; $display("FAIL turn_timeout: got %0d want 5", mode); end
    n_cmp++; if (left_pwm !== 1'b0 || right_pwm !== 1'b0) begin n_err++;
      $display("FAIL halt_pwm: got %b%b want 00", left_pwm, right_pwm); end
    step(3);
    n_cmp++; if (mode !== 3'd5) begin n_err++; $display("FAIL halt_hold: got %0d want 5", mode); end
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL halt_start: got %0d want 1", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd3) begin n_err++; $display("FAIL rt_reenter: got %0d want 3", mode); end
  endtask

  task automatic test_stop;
    track_state = 2'd1;
    step(4);
    n_cmp++; if (mode !== 3'd3) begin n_err++; $display("FAIL rt_hold: got %0d want 3", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL rt_to_fwd: got %0d want 1", mode); end
    track_state = 2'd0;
    step(4);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL stop_filt_edge: got %0d want 1", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd5) begin n_err++; $display("FAIL stop_halt: got %0d want 5", mode); end
    n_cmp++; if (left_pwm !== 1'b0 || right_pwm !== 1'b0) begin n_err++;
      $display("FAIL stop_pwm: got %b%b want 00", left_pwm, right_pwm); end
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL stop_restart: got %0d want 1", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd5) begin n_err++; $display("FAIL stop_rehalt: got %0d want 5", mode); end
  endtask

  task automatic test_obstacle_and_stop;
    track_state = 2'd1;
    step(4);
    n_cmp++; if (mode !== 3'd5) begin n_err++; $display("FAIL halt_ignores_track: got %0d want 5", mode); end
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL fwd_again: got %0d want 1", mode); end
    track_state = 2'd0;
    step(3);
    obstacle = 1'b1;
    step(1);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL both_pre: got %0d want 1", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd4) begin n_err++; $display("FAIL both_blocked: got %0d want 4", mode); end
    obstacle = 1'b0;
    step(8);
    n_cmp++; if (mode !== 3'd4) begin n_err++; $display("FAIL both_hold: got %0d want 4", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL both_exit: got %0d want 1", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd5) begin n_err++; $display("FAIL both_halt: got %0d want 5", mode); end
  endtask

  task automatic test_reset_mid;
    int lh, rh;
    track_state = 2'd1;
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL pre_reset_fwd: got %0d want 1", mode); end
    measure_frame(lh, rh);
    n_cmp++; if (lh !== 12 || rh !== 12) begin n_err++;
      $display("FAIL fwd_duty3: got %0d/%0d want 12/12", lh, rh); end
    step(3);
    n_cmp++; if (left_pwm !== 1'b1 || right_pwm !== 1'b1) begin n_err++;
      $display("FAIL mid_frame_pwm: got %b%b want 11", left_pwm, right_pwm); end
    track_state = 2'd3;
    step(2);
    reset = 1'b1;
    step(1);
    n_cmp++; if (mode !== 3'd0) begin n_err++; $display("FAIL mid_reset_mode: got %0d want 0", mode); end
    n_cmp++; if (left_pwm !== 1'b0 || right_pwm !== 1'b0) begin n_err++;
      $display("FAIL mid_reset_pwm: got %b%b want 00", left_pwm, right_pwm); end
    reset = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL post_reset_fwd: got %0d want 1", mode); end
    step(3);
    n_cmp++; if (mode !== 3'd1) begin n_err++; $display("FAIL no_residual_deb: got %0d want 1", mode); end
    step(1);
    n_cmp++; if (mode !== 3'd2) begin n_err++; $display("FAIL post_reset_lt: got %0d want 2", mode); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    track_state = 2'd1;
    obstacle = 1'b0;
    test_reset();
    test_fwd();
    test_debounce();
    test_blocked();
    test_turn_timeout();
    test_stop();
    test_obstacle_and_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
